// File: rtl/iir_lowpass.sv
`default_nettype none
// ============================================================================
// Module   : iir_lowpass
// Purpose  : Second-order (biquad) Direct Form I IIR lowpass filter for
//            signed PCM audio. One input sample is consumed per I_DV strobe.
//            One filtered sample appears on DO with a one-cycle O_DV pulse,
//            exactly one clock after the input is accepted. Default
//            coefficients give a Butterworth lowpass, fc = 1 kHz at
//            fs = 48 kHz, Q1.14, unity DC gain.
// Ports    : CLK   - system clock, rising edge
//            RESET - synchronous active-high reset; wins over I_DV
//            I_DV  - input sample valid
//            DI    - input sample, signed DATA_W
//            O_DV  - output valid, one-cycle pulse per accepted input
//            DO    - filtered output sample, signed DATA_W
// Options  : IIR_LOWPASS_SATURATE_EN - when defined, the output is clamped
//            to the DATA_W signed range. When undefined, the output wraps
//            (two's-complement truncation).
// Revision : 1.0 - initial release
// ============================================================================
module iir_lowpass #(
    parameter int                        DATA_W = 16,
    parameter int                        COEF_W = 16,
    parameter int                        FRAC   = 14,
    parameter logic signed [COEF_W-1:0]  B0     = COEF_W'(64),
    parameter logic signed [COEF_W-1:0]  B1     = COEF_W'(128),
    parameter logic signed [COEF_W-1:0]  B2     = COEF_W'(64),
    parameter logic signed [COEF_W-1:0]  A1     = COEF_W'(-29743),
    parameter logic signed [COEF_W-1:0]  A2     = COEF_W'(13615),
    parameter int                        ACC_W  = 40
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     I_DV,
    input  logic signed [DATA_W-1:0] DI,
    output logic                     O_DV,
    output logic signed [DATA_W-1:0] DO
);

    // Coefficients sign-extended to the accumulator width. Every product is
    // then formed at ACC_W. The true product needs at most
    // DATA_W + COEF_W bits, so the low ACC_W bits of the product are exact.
    localparam logic signed [ACC_W-1:0] C_B0 = {{(ACC_W-COEF_W){B0[COEF_W-1]}}, B0};
    localparam logic signed [ACC_W-1:0] C_B1 = {{(ACC_W-COEF_W){B1[COEF_W-1]}}, B1};
    localparam logic signed [ACC_W-1:0] C_B2 = {{(ACC_W-COEF_W){B2[COEF_W-1]}}, B2};
    localparam logic signed [ACC_W-1:0] C_A1 = {{(ACC_W-COEF_W){A1[COEF_W-1]}}, A1};
    localparam logic signed [ACC_W-1:0] C_A2 = {{(ACC_W-COEF_W){A2[COEF_W-1]}}, A2};

    // Half an LSB of the output, used for round-half-up before the shift.
    localparam logic signed [ACC_W-1:0] C_HALF = ACC_W'(longint'(1) << (FRAC - 1));

`ifdef IIR_LOWPASS_SATURATE_EN
    localparam logic signed [ACC_W-1:0] C_YMAX = ACC_W'((longint'(1) << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] C_YMIN = ACC_W'(-(longint'(1) << (DATA_W - 1)));
`endif

    // History registers and output registers
    logic signed [DATA_W-1:0] x1_q, x1_d;
    logic signed [DATA_W-1:0] x2_q, x2_d;
    logic signed [DATA_W-1:0] y1_q, y1_d;
    logic signed [DATA_W-1:0] y2_q, y2_d;
    logic signed [DATA_W-1:0] do_q, do_d;
    logic                     odv_q, odv_d;

    // Sign-extended operands
    logic signed [ACC_W-1:0] di_ext;
    logic signed [ACC_W-1:0] x1_ext;
    logic signed [ACC_W-1:0] x2_ext;
    logic signed [ACC_W-1:0] y1_ext;
    logic signed [ACC_W-1:0] y2_ext;

    // Datapath
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_rnd;
    logic signed [ACC_W-1:0]  y_full;
    logic signed [DATA_W-1:0] y_lim;

    assign di_ext = {{(ACC_W-DATA_W){DI[DATA_W-1]}},   DI};
    assign x1_ext = {{(ACC_W-DATA_W){x1_q[DATA_W-1]}}, x1_q};
    assign x2_ext = {{(ACC_W-DATA_W){x2_q[DATA_W-1]}}, x2_q};
    assign y1_ext = {{(ACC_W-DATA_W){y1_q[DATA_W-1]}}, y1_q};
    assign y2_ext = {{(ACC_W-DATA_W){y2_q[DATA_W-1]}}, y2_q};

    // Direct Form I sum. The feedback terms are subtracted, so the A
    // coefficients carry the sign convention of the denominator polynomial.
    assign acc = (C_B0 * di_ext) + (C_B1 * x1_ext) + (C_B2 * x2_ext)
               - (C_A1 * y1_ext) - (C_A2 * y2_ext);

    assign acc_rnd = acc + C_HALF;
    assign y_full  = acc_rnd >>> FRAC;

`ifdef IIR_LOWPASS_SATURATE_EN
    always_comb begin
        y_lim = DATA_W'(y_full);
        if (y_full > C_YMAX) begin
            y_lim = DATA_W'(C_YMAX);
        end else if (y_full < C_YMIN) begin
            y_lim = DATA_W'(C_YMIN);
        end
    end
`else
    // Plain two's-complement wrap. The wrapped value also feeds back through
    // y1, which can produce large artifacts on near-full-scale input.
    assign y_lim = DATA_W'(y_full);
`endif

    // Next-state: history shifts only on an accepted sample.
    always_comb begin
        x1_d  = x1_q;
        x2_d  = x2_q;
        y1_d  = y1_q;
        y2_d  = y2_q;
        do_d  = do_q;
        odv_d = 1'b0;
        if (I_DV) begin
            x2_d  = x1_q;
            x1_d  = DI;
            y2_d  = y1_q;
            y1_d  = y_lim;
            do_d  = y_lim;
            odv_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            x1_q  <= '0;
            x2_q  <= '0;
            y1_q  <= '0;
            y2_q  <= '0;
            do_q  <= '0;
            odv_q <= 1'b0;
        end else begin
            x1_q  <= x1_d;
            x2_q  <= x2_d;
            y1_q  <= y1_d;
            y2_q  <= y2_d;
            do_q  <= do_d;
            odv_q <= odv_d;
        end
    end

    assign DO   = do_q;
    assign O_DV = odv_q;

endmodule
`default_nettype wire

// File: tb/tb_iir_lowpass.sv
`default_nettype none
// ============================================================================
// Module   : tb_iir_lowpass
// Purpose  : Self-checking bench for iir_lowpass. Each output is compared
//            against a sample-level difference-equation model.
//            IIR_LOWPASS_SATURATE_EN selects the same output limiting in the
//            model as in the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iir_lowpass;

    localparam longint B0 = 64;
    localparam longint B1 = 128;
    localparam longint B2 = 64;
    localparam longint A1 = -29743;
    localparam longint A2 = 13615;

    logic               CLK;
    logic               RESET;
    logic               I_DV;
    logic signed [15:0] DI;
    logic               O_DV;
    logic signed [15:0] DO;

    int n_checks;
    int n_errors;

    // Reference model history
    longint m_x1, m_x2, m_y1, m_y2;
    longint last_out;

    longint q_b2b[$];
    longint q_gap[$];
    logic   [15:0] samples[20];

    iir_lowpass dut (
        .CLK   (CLK),
        .RESET (RESET),
        .I_DV  (I_DV),
        .DI    (DI),
        .O_DV  (O_DV),
        .DO    (DO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint model_y(input longint di);
        longint acc;
        longint y;
        acc = B0 * di + B1 * m_x1 + B2 * m_x2 - A1 * m_y1 - A2 * m_y2;
        y = (acc + 8192) >>> 14;
`ifdef IIR_LOWPASS_SATURATE_EN
        if (y > 32767) y = 32767;
        else if (y < -32768) y = -32768;
`else
        y = ((y + 32768) & 65535) - 32768;
`endif
        return y;
    endfunction

    task automatic model_clear();
        m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0;
        last_out = 0;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns after the
    // rising edge that consumed them.
    task automatic drive(input logic rst, input logic dv, input logic signed [15:0] d);
        @(negedge CLK);
        RESET = rst;
        I_DV  = dv;
        DI    = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input longint di, output longint y);
        longint exp;
        exp = model_y(di);
        drive(1'b0, 1'b1, 16'(di));
        check_eq("send_dv", longint'(O_DV), 1);
        check_eq("send_do", longint'(DO), exp);
        m_x2 = m_x1; m_x1 = di;
        m_y2 = m_y1; m_y1 = exp;
        last_out = exp;
        y = longint'(DO);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 16'($urandom));
        check_eq("idle_dv", longint'(O_DV), 0);
        check_eq("idle_hold", longint'(DO), last_out);
    endtask

    task automatic apply_reset(input int cycles, input logic signed [15:0] d);
        for (int i = 0; i < cycles; i++) begin
            drive(1'b1, 1'b1, d);
            check_eq("rst_dv", longint'(O_DV), 0);
            check_eq("rst_do", longint'(DO), 0);
        end
        model_clear();
    endtask

    initial begin
        longint y;
        longint ymax, ymin, amax;
        bit     saw_neg, saw_top;

        n_checks = 0;
        n_errors = 0;
        RESET = 1'b1;
        I_DV  = 1'b0;
        DI    = '0;
        model_clear();

        // Reset with I_DV asserted, then a zero sample after release
        apply_reset(3, 16'sd1000);
        send(0, y);
        check_eq("post_rst_zero", y, 0);

        // Impulse response
        apply_reset(1, 16'sd0);
        send(16384, y);
        check_eq("impulse_0", y, 64);
        send(0, y);
        check_eq("impulse_1", y, 244);
        for (int i = 0; i < 20; i++) send(0, y);

        // DC step: unity gain, overshoot below 5 %. Fixed-point rounding in
        // the feedback loop leaves a small dead band around the final value.
        apply_reset(1, 16'sd0);
        ymax = -100000;
        for (int i = 0; i < 2000; i++) begin
            send(10000, y);
            if (y > ymax) ymax = y;
        end
        check_eq("dc_overshoot_lt5pct", longint'(ymax < 10500), 1);
        check_eq("dc_settled", longint'(y >= 9969 && y <= 10031), 1);

        // Nyquist rejection
        apply_reset(1, 16'sd0);
        amax = 0;
        for (int i = 0; i < 500; i++) begin
            send((i % 2 == 0) ? 20000 : -20000, y);
            if (i >= 200 && (y > amax || -y > amax)) amax = (y < 0) ? -y : y;
        end
        check_eq("nyquist_small", longint'(amax < 100), 1);

        // Back-to-back versus gapped run with identical samples
        for (int i = 0; i < 20; i++) samples[i] = 16'($urandom_range(0, 40000) - 20000);
        apply_reset(1, 16'sd0);
        for (int i = 0; i < 20; i++) begin
            send(longint'($signed(samples[i])), y);
            q_b2b.push_back(y);
        end
        apply_reset(1, 16'sd0);
        for (int i = 0; i < 20; i++) begin
            send(longint'($signed(samples[i])), y);
            q_gap.push_back(y);
            for (int k = 0; k < 4; k++) idle();
        end
        for (int i = 0; i < 20; i++) check_eq("gap_vs_b2b", q_gap[i], q_b2b[i]);

        // Reset in the middle of a stream discards the simultaneous sample
        send(12345, y);
        apply_reset(1, 16'sd30000);
        send(0, y);
        check_eq("midrst_zero", y, 0);

        // Full-scale step: clamp or wrap depending on the build
        apply_reset(1, 16'sd0);
        ymax = -100000; ymin = 100000; saw_neg = 1'b0; saw_top = 1'b0;
        for (int i = 0; i < 300; i++) begin
            send(32767, y);
            if (y > ymax) ymax = y;
            if (y < ymin) ymin = y;
            if (y < 0) saw_neg = 1'b1;
            if (y == 32767) saw_top = 1'b1;
        end
`ifdef IIR_LOWPASS_SATURATE_EN
        check_eq("sat_max", ymax, 32767);
        check_eq("sat_reached", longint'(saw_top), 1);
        check_eq("sat_no_wrap", longint'(ymin >= 0), 1);
`else
        check_eq("wrap_negative", longint'(saw_neg), 1);
`endif

        // Random samples with random gaps
        apply_reset(1, 16'sd0);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0) send(longint'($urandom_range(0, 65535)) - 32768, y);
            else idle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
